// File: rtl/t5_dmem_if.sv
// rtl/t5_dmem_if.sv - Wishbone-classic data bus between the memory stage and the data port
interface t5_dmem_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] adr;
    logic [XLEN-1:0] dto;
    logic [3:0]      sel;
    logic            stb;
    logic            wre;
    logic [XLEN-1:0] dti;
    logic            ack;

    modport master (
        output adr, dto, sel, stb, wre,
        input  dti, ack
    );

    modport slave (
        input  adr, dto, sel, stb, wre,
        output dti, ack
    );
endinterface

// File: rtl/t5_dmem.sv
// rtl/t5_dmem.sv - memory-stage load/store unit with Wishbone data master and bus watchdog
module t5_dmem #(
    parameter int         XLEN = 32,
    parameter logic [7:0] TMO  = 8'd255
) (
    input  logic            sclk,
    input  logic            srst,
    input  logic            sena,
    input  logic [6:2]      dopc,
    input  logic [14:12]    dfn3,
    input  logic [XLEN-1:0] dea,
    input  logic [XLEN-1:0] drs2,
    t5_dmem_if.master       dwb,
    output logic [3:0]      xsel,
    output logic [2:0]      xfn3,
    output logic            xstb,
    output logic            xwre,
    output logic [XLEN-1:0] xdti,
    output logic            xmis,
    output logic            xerr,
    output logic            dstall
);

    typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_t;

    state_t          state;
    logic [7:0]      wdog;
    logic [7:0]      wdog_nxt;
    logic [XLEN-1:0] held;
    logic [XLEN-1:0] adr_q;
    logic [XLEN-1:0] dto_q;
    logic [3:0]      sel_q;
    logic            stb_q;
    logic            wre_q;

    logic            is_load;
    logic            is_store;
    logic            is_mem;
    logic            mis;
    logic [3:0]      lane_sel;
    logic [XLEN-1:0] st_data;

    assign is_load  = (dopc == 5'b00000);
    assign is_store = (dopc == 5'b01000);
    assign is_mem   = is_load | is_store;

    // funct3[13:12]: 00 byte, 01 half, anything wider is treated as a full word
    always_comb begin
        lane_sel = 4'hF;
        st_data  = drs2;
        mis      = 1'b0;
        case (dfn3[13:12])
            2'b00: begin
                if (is_mem) lane_sel = 4'b0001 << dea[1:0];
                st_data = {(XLEN/8){drs2[7:0]}};
            end
            2'b01: begin
                if (is_mem) lane_sel = dea[1] ? 4'hC : 4'h3;
                st_data = {(XLEN/16){drs2[15:0]}};
                mis     = is_mem & dea[0];
            end
            default: begin
                mis = is_mem & (dea[1:0] != 2'b00);
            end
        endcase
    end

    assign wdog_nxt = (wdog == TMO) ? wdog : wdog + 8'd1;

    always_ff @(posedge sclk) begin
        if (srst) begin
            state <= IDLE;
            wdog  <= 8'd0;
            held  <= '0;
            adr_q <= '0;
            dto_q <= '0;
            sel_q <= 4'h0;
            stb_q <= 1'b0;
            wre_q <= 1'b0;
            xsel  <= 4'hF;
            xfn3  <= 3'd0;
            xmis  <= 1'b0;
            xerr  <= 1'b0;
        end else if (sena) begin
            // a pipeline advance always retires whatever was in flight
            xsel  <= lane_sel;
            xfn3  <= dfn3;
            xmis  <= mis;
            xerr  <= 1'b0;
            adr_q <= {dea[XLEN-1:2], 2'b00};
            sel_q <= lane_sel;
            dto_q <= st_data;
            wre_q <= is_store;
            if (is_mem && !mis) begin
                state <= BUSY;
                stb_q <= 1'b1;
                wdog  <= 8'd0;
            end else begin
                state <= IDLE;
                stb_q <= 1'b0;
            end
        end else begin
            case (state)
                BUSY: begin
                    if (dwb.ack) begin
                        state <= HOLD;
                        held  <= dwb.dti;
                        stb_q <= 1'b0;
                    end else begin
                        wdog <= wdog_nxt;
                        if (wdog_nxt == TMO) begin
                            state <= HOLD;
                            held  <= '0;
                            xerr  <= 1'b1;
                            stb_q <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign dwb.adr = adr_q;
    assign dwb.dto = dto_q;
    assign dwb.sel = sel_q;
    assign dwb.stb = stb_q;
    assign dwb.wre = wre_q;

    assign xstb   = (state != IDLE);
    assign xwre   = wre_q;
    assign xdti   = (state == HOLD) ? held : dwb.dti;
    // the single-cycle ack releases the stall so writeback captures on the ack edge
    assign dstall = (state == BUSY) && !dwb.ack && (wdog < TMO);

endmodule

// File: tb/tb_t5_dmem.sv
// tb/tb_t5_dmem.sv - directed self-checking bench for t5_dmem
module tb_t5_dmem;

    logic        sclk;
    logic        srst;
    logic        sena;
    logic [6:2]  dopc;
    logic [14:12] dfn3;
    logic [31:0] dea;
    logic [31:0] drs2;
    logic [3:0]  xsel;
    logic [2:0]  xfn3;
    logic        xstb;
    logic        xwre;
    logic [31:0] xdti;
    logic        xmis;
    logic        xerr;
    logic        dstall;

    int vecs = 0;
    int errs = 0;

    t5_dmem_if #(.XLEN(32)) bus ();

    t5_dmem #(.XLEN(32), .TMO(8'd255)) dut (
        .sclk   (sclk),
        .srst   (srst),
        .sena   (sena),
        .dopc   (dopc),
        .dfn3   (dfn3),
        .dea    (dea),
        .drs2   (drs2),
        .dwb    (bus),
        .xsel   (xsel),
        .xfn3   (xfn3),
        .xstb   (xstb),
        .xwre   (xwre),
        .xdti   (xdti),
        .xmis   (xmis),
        .xerr   (xerr),
        .dstall (dstall)
    );

    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    localparam logic [4:0] OP_LOAD  = 5'b00000;
    localparam logic [4:0] OP_STORE = 5'b01000;
    localparam logic [4:0] OP_ALU   = 5'b01100;

    task automatic tick;
        @(posedge sclk);
        #1;
    endtask

    task automatic set_op(input logic [4:0] opc, input logic [2:0] fn3,
                          input logic [31:0] ea, input logic [31:0] rs2);
        dopc = opc;
        dfn3 = fn3;
        dea  = ea;
        drs2 = rs2;
        sena = 1'b1;
    endtask

    task automatic test_reset;
        srst = 1'b1;
        set_op(OP_LOAD, 3'b010, 32'h0000_1234, 32'h5555_5555);
        bus.ack = 1'b1;
        bus.dti = 32'h9999_9999;
        tick;
        tick;
        vecs++; if (bus.stb !== 1'b0) begin errs++; $display("FAIL rst_stb got %b want 0", bus.stb); end
        vecs++; if (bus.wre !== 1'b0) begin errs++; $display("FAIL rst_wre got %b want 0", bus.wre); end
        vecs++; if (bus.sel !== 4'h0) begin errs++; $display("FAIL rst_sel got %h want 0", bus.sel); end
        vecs++; if (bus.adr !== 32'h0) begin errs++; $display("FAIL rst_adr got %h want 0", bus.adr); end
        vecs++; if (bus.dto !== 32'h0) begin errs++; $display("FAIL rst_dto got %h want 0", bus.dto); end
        vecs++; if (xsel !== 4'hF) begin errs++; $display("FAIL rst_xsel got %h want f", xsel); end
        vecs++; if (xfn3 !== 3'd0) begin errs++; $display("FAIL rst_xfn3 got %h want 0", xfn3); end
        vecs++; if (xmis !== 1'b0 || xerr !== 1'b0) begin errs++; $display("FAIL rst_flags got mis=%b err=%b want 0 0", xmis, xerr); end
        vecs++; if (xstb !== 1'b0 || dstall !== 1'b0) begin errs++; $display("FAIL rst_state got xstb=%b dstall=%b want 0 0", xstb, dstall); end
        srst = 1'b0;
        sena = 1'b0;
        bus.ack = 1'b0;
        tick;
    endtask

    task automatic test_store_byte;
        int stalls;
        bus.dti = 32'h0;
        set_op(OP_STORE, 3'b000, 32'h0000_1003, 32'h0000_00AB);
        tick;
        sena = 1'b0;
        vecs++; if (bus.sel !== 4'h8) begin errs++; $display("FAIL sb_sel got %h want 8", bus.sel); end
        vecs++; if (bus.dto !== 32'hABAB_ABAB) begin errs++; $display("FAIL sb_dto got %h want ababab ab", bus.dto); end
        vecs++; if (bus.adr !== 32'h0000_1000) begin errs++; $display("FAIL sb_adr got %h want 00001000", bus.adr); end
        vecs++; if (bus.wre !== 1'b1 || bus.stb !== 1'b1) begin errs++; $display("FAIL sb_wre_stb got %b%b want 11", bus.wre, bus.stb); end
        vecs++; if (xstb !== 1'b1 || xwre !== 1'b1 || xsel !== 4'h8) begin errs++; $display("FAIL sb_x got xstb=%b xwre=%b xsel=%h want 1 1 8", xstb, xwre, xsel); end
        stalls = 0;
        for (int i = 0; i < 2; i++) begin
            if (dstall === 1'b1) stalls++;
            tick;
        end
        vecs++; if (bus.adr !== 32'h0000_1000 || bus.stb !== 1'b1) begin errs++; $display("FAIL sb_stable got adr=%h stb=%b want 00001000 1", bus.adr, bus.stb); end
        bus.ack = 1'b1;
        #1;
        vecs++; if (stalls !== 2 || dstall !== 1'b0) begin errs++; $display("FAIL sb_stall got %0d cycles, now %b want 2, 0", stalls, dstall); end
        set_op(OP_ALU, 3'b000, 32'h0, 32'h0);
        tick;
        bus.ack = 1'b0;
        sena = 1'b0;
        vecs++; if (bus.stb !== 1'b0 || xstb !== 1'b0) begin errs++; $display("FAIL sb_done got stb=%b xstb=%b want 0 0", bus.stb, xstb); end
    endtask

    task automatic test_load_half;
        set_op(OP_LOAD, 3'b001, 32'h0000_2002, 32'h0);
        tick;
        sena = 1'b0;
        vecs++; if (xsel !== 4'hC || bus.sel !== 4'hC) begin errs++; $display("FAIL lh_sel got %h/%h want c/c", xsel, bus.sel); end
        vecs++; if (bus.adr !== 32'h0000_2000 || bus.wre !== 1'b0 || bus.stb !== 1'b1) begin errs++; $display("FAIL lh_bus got adr=%h wre=%b stb=%b want 00002000 0 1", bus.adr, bus.wre, bus.stb); end
        bus.dti = 32'h1234_5678;
        bus.ack = 1'b1;
        set_op(OP_ALU, 3'b000, 32'h0, 32'h0);
        #1;
        vecs++; if (xdti !== 32'h1234_5678 || dstall !== 1'b0) begin errs++; $display("FAIL lh_xdti got %h stall=%b want 12345678 0", xdti, dstall); end
        tick;
        bus.ack = 1'b0;
        sena = 1'b0;
        vecs++; if (bus.stb !== 1'b0 || xstb !== 1'b0) begin errs++; $display("FAIL lh_idle got stb=%b xstb=%b want 0 0", bus.stb, xstb); end
    endtask

    task automatic test_load_hold;
        set_op(OP_LOAD, 3'b010, 32'h0000_4000, 32'h0);
        tick;
        sena = 1'b0;
        tick;
        bus.dti = 32'hCAFE_F00D;
        bus.ack = 1'b1;
        tick;
        bus.ack = 1'b0;
        bus.dti = 32'h1111_1111;
        #1;
        vecs++; if (bus.stb !== 1'b0 || xstb !== 1'b1 || dstall !== 1'b0) begin errs++; $display("FAIL hold_state got stb=%b xstb=%b stall=%b want 0 1 0", bus.stb, xstb, dstall); end
        vecs++; if (xdti !== 32'hCAFE_F00D) begin errs++; $display("FAIL hold_data got %h want cafef00d", xdti); end
        bus.ack = 1'b1;
        for (int i = 0; i < 3; i++) tick;
        bus.ack = 1'b0;
        vecs++; if (xdti !== 32'hCAFE_F00D || xstb !== 1'b1) begin errs++; $display("FAIL hold_stable got %h xstb=%b want cafef00d 1", xdti, xstb); end
        set_op(OP_ALU, 3'b000, 32'h0, 32'h0);
        tick;
        sena = 1'b0;
        vecs++; if (xstb !== 1'b0 || xdti !== 32'h1111_1111) begin errs++; $display("FAIL hold_release got xstb=%b xdti=%h want 0 11111111", xstb, xdti); end
    endtask

    task automatic test_misaligned;
        int stb_seen;
        set_op(OP_LOAD, 3'b010, 32'h0000_3001, 32'h0);
        tick;
        sena = 1'b0;
        stb_seen = 0;
        for (int i = 0; i < 3; i++) begin
            if (bus.stb !== 1'b0 || dstall !== 1'b0) stb_seen++;
            tick;
        end
        vecs++; if (xmis !== 1'b1) begin errs++; $display("FAIL mis_word got xmis=%b want 1", xmis); end
        vecs++; if (stb_seen !== 0 || xstb !== 1'b0) begin errs++; $display("FAIL mis_nobus got %0d busy cycles xstb=%b want 0 0", stb_seen, xstb); end
        set_op(OP_STORE, 3'b001, 32'h0000_3003, 32'h0);
        tick;
        sena = 1'b0;
        vecs++; if (xmis !== 1'b1 || bus.stb !== 1'b0) begin errs++; $display("FAIL mis_half got xmis=%b stb=%b want 1 0", xmis, bus.stb); end
        set_op(OP_LOAD, 3'b101, 32'h0000_3002, 32'h0);
        tick;
        bus.ack = 1'b1;
        set_op(OP_ALU, 3'b000, 32'h0, 32'h0);
        vecs++; if (xmis !== 1'b0 || bus.stb !== 1'b1 || xsel !== 4'hC || xfn3 !== 3'b101) begin errs++; $display("FAIL mis_aligned got xmis=%b stb=%b xsel=%h xfn3=%h want 0 1 c 5", xmis, bus.stb, xsel, xfn3); end
        tick;
        bus.ack = 1'b0;
        sena = 1'b0;
    endtask

    task automatic test_timeout;
        int n;
        bus.dti = 32'hDEAD_BEEF;
        set_op(OP_LOAD, 3'b010, 32'h0000_5004, 32'h0);
        tick;
        sena = 1'b0;
        n = 0;
        while (dstall === 1'b1 && n < 400) begin
            n++;
            tick;
        end
        vecs++; if (n !== 255) begin errs++; $display("FAIL tmo_cycles got %0d want 255", n); end
        vecs++; if (xerr !== 1'b1 || xdti !== 32'h0 || bus.stb !== 1'b0) begin errs++; $display("FAIL tmo_result got err=%b xdti=%h stb=%b want 1 0 0", xerr, xdti, bus.stb); end
        set_op(OP_ALU, 3'b000, 32'h0, 32'h0);
        tick;
        sena = 1'b0;
        vecs++; if (xerr !== 1'b0 || xstb !== 1'b0) begin errs++; $display("FAIL tmo_clear got err=%b xstb=%b want 0 0", xerr, xstb); end
    endtask

    task automatic test_back_to_back;
        set_op(OP_STORE, 3'b010, 32'h0000_6000, 32'h0102_0304);
        tick;
        sena = 1'b0;
        tick;
        vecs++; if (bus.dto !== 32'h0102_0304 || bus.sel !== 4'hF || bus.stb !== 1'b1) begin errs++; $display("FAIL b2b_first got dto=%h sel=%h stb=%b want 01020304 f 1", bus.dto, bus.sel, bus.stb); end
        bus.ack = 1'b1;
        set_op(OP_LOAD, 3'b100, 32'h0000_7001, 32'h0);
        tick;
        bus.ack = 1'b0;
        sena = 1'b0;
        vecs++; if (bus.stb !== 1'b1 || bus.adr !== 32'h0000_7000 || bus.sel !== 4'h2 || bus.wre !== 1'b0) begin errs++; $display("FAIL b2b_second got stb=%b adr=%h sel=%h wre=%b want 1 00007000 2 0", bus.stb, bus.adr, bus.sel, bus.wre); end
        bus.ack = 1'b1;
        set_op(OP_ALU, 3'b000, 32'h0, 32'h0);
        tick;
        bus.ack = 1'b0;
        sena = 1'b0;
    endtask

    task automatic test_reset_mid;
        set_op(OP_LOAD, 3'b010, 32'h0000_8000, 32'h0);
        tick;
        sena = 1'b0;
        tick;
        srst = 1'b1;
        tick;
        srst = 1'b0;
        vecs++; if (bus.stb !== 1'b0 || xsel !== 4'hF || xstb !== 1'b0) begin errs++; $display("FAIL rstmid got stb=%b xsel=%h xstb=%b want 0 f 0", bus.stb, xsel, xstb); end
        bus.ack = 1'b1;
        bus.dti = 32'h7777_7777;
        tick;
        bus.ack = 1'b0;
        #1;
        vecs++; if (bus.stb !== 1'b0 || xstb !== 1'b0 || dstall !== 1'b0) begin errs++; $display("FAIL late_ack got stb=%b xstb=%b stall=%b want 0 0 0", bus.stb, xstb, dstall); end
    endtask

    initial begin
        srst    = 1'b1;
        sena    = 1'b0;
        dopc    = 5'b0;
        dfn3    = 3'b0;
        dea     = 32'h0;
        drs2    = 32'h0;
        bus.ack = 1'b0;
        bus.dti = 32'h0;
        test_reset;
        test_store_byte;
        test_load_half;
        test_load_hold;
        test_misaligned;
        test_timeout;
        test_back_to_back;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/t5_dmem.md
T5_DMEM -- requirements
Module: t5_dmem

Interface
REQ-001 Parameter XLEN, default 32: datapath width.
REQ-002 Parameter TMO, default 255: bus watchdog limit in cycles, 8-bit.
REQ-003 sclk  in  1  clock; all state changes on posedge sclk.
REQ-004 srst  in  1  reset, synchronous, active-high.
REQ-005 sena  in  1  pipeline advance enable; the block captures a new operation only on an edge with sena=1.
REQ-006 dopc[6:2] in 5, dfn3[14:12] in 3, dea in XLEN, drs2 in XLEN: opcode, funct3, effective address and store data of the entering instruction.
REQ-007 dwb_adr out XLEN, dwb_dto out XLEN, dwb_sel out 4, dwb_stb out 1, dwb_wre out 1, dwb_dti in XLEN, dwb_ack in 1: Wishbone-classic data master port; dwb_adr is word-aligned.
REQ-008 xsel out 4, xfn3 out 3, xstb out 1, xwre out 1, xdti out XLEN: lane select, funct3, strobe, write flag and read data for the writeback stage.
REQ-009 xmis out 1, xerr out 1, dstall out 1: misaligned access, bus timeout, and stall request (combinational).

Function
REQ-010 Load is dopc=5'b00000; store is dopc=5'b01000; every other opcode is non-memory.
REQ-011 Lane select from dfn3[13:12] and dea[1:0]: byte -> 4'b0001<<dea[1:0]; half -> 4'h3 if dea[1]=0, else 4'hC; word -> 4'hF; non-memory -> 4'hF.
REQ-012 Store data replication: byte {4{drs2[7:0]}}, half {2{drs2[15:0]}}, word drs2.
REQ-013 Misaligned: half with dea[0]=1, word with dea[1:0]!=0; it sets xmis=1, issues no bus cycle, and the state goes to IDLE.
REQ-014 On a sena=1 edge, xsel, xfn3, xmis, dwb_adr={dea[XLEN-1:2],2'b00}, dwb_sel, dwb_dto and dwb_wre are registered, and xerr clears.
REQ-015 States: IDLE, BUSY, HOLD; xstb=1 in BUSY or HOLD; xwre mirrors dwb_wre.
REQ-016 Transitions on a sena=1 edge from any state: an aligned memory op -> BUSY with dwb_stb=1 on the next cycle; otherwise -> IDLE with dwb_stb=0.
REQ-017 In BUSY with sena=0: dwb_ack=1 -> HOLD with held data = dwb_dti and dwb_stb=0.
REQ-018 In BUSY with sena=0: the watchdog reaches TMO -> HOLD with held data = 0, xerr=1 and dwb_stb=0.
REQ-019 HOLD with sena=0 stays in HOLD with data stable.
REQ-020 dwb_stb, dwb_adr, dwb_sel, dwb_dto and dwb_wre stay stable throughout BUSY until ack or timeout.
REQ-021 xdti = held data in HOLD; otherwise xdti = dwb_dti.
REQ-022 dstall = 1 iff state=BUSY and dwb_ack=0 and the watchdog is below TMO; the single-cycle ack therefore coincides with the writeback capture edge.
REQ-023 Ack in BUSY with sena=1 completes the transfer on that edge; a following memory op keeps dwb_stb=1 back-to-back with new address/sel.
REQ-024 The watchdog clears on entry to BUSY and increments each BUSY cycle without ack.
REQ-025 The watchdog saturates at TMO and does not wrap.
REQ-026 dwb_ack outside BUSY is ignored.

Reset
REQ-027 While srst=1, regardless of sena or ack, the state is IDLE and the watchdog is 0.
REQ-028 While srst=1, dwb_stb=0, dwb_wre=0, dwb_sel=0, dwb_adr=0, dwb_dto=0, xsel=4'hF, xfn3=0 and held data=0.
REQ-029 While srst=1, xmis=0 and xerr=0; srst asserted mid-transfer drops dwb_stb on the next edge.

Verification
REQ-030 Store byte, dea=0x1003, drs2=0xAB, ack after 2 wait cycles -> dwb_sel=8, dwb_dto=0xABABABAB, dwb_adr=0x1000, dwb_wre=1, dstall high for 2 cycles.
REQ-031 Load half, dea=0x2002, dwb_dti=0x1234_5678, ack with sena=1 -> xsel=4'hC, xdti=0x12345678 at that edge, then IDLE.
REQ-032 Load word, sena=0 externally at ack -> HOLD, dwb_stb=0, xdti stays at the acked data until sena=1.
REQ-033 Load word, dea=0x3001 -> xmis=1, dwb_stb never asserted, dstall=0.
REQ-034 No ack, TMO=255 -> dstall drops after 255 BUSY cycles, xerr=1, xdti=0, dwb_stb=0.
REQ-035 srst asserted during BUSY -> next edge dwb_stb=0, xsel=4'hF, state IDLE; a late ack is ignored.
